conv_pack_8to64: RTL and testbench

CONV_PACK_8TO64 -- requirements
Module: conv_pack_8to64

---
 rtl/conv_pkg.sv | 16 +
 rtl/conv_pack_8to64_if.sv | 25 ++
 rtl/conv_out_reg.sv | 36 +++
 rtl/conv_pack_8to64.sv | 111 +++++++++++
 tb/tb_conv_pack_8to64.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared widths and FSM encoding for the 8-to-64 byte packer.
// Latency/backpressure: none (declarations only).
package conv_pkg;

  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 8;
  localparam int WORD_W         = 64;
  localparam int CNT_W          = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/conv_pack_8to64_if.sv
// Byte-in / word-out handshake bundle; master is the byte producer and word consumer.
// Latency/backpressure: wires only; valid/ready on both sides.
interface conv_pack_8to64_if;
  import conv_pkg::*;

  logic                      valid_in;
  logic [BYTE_W-1:0]         data_in;
  logic                      last_in;
  logic                      ready_in;
  logic                      valid_out;
  logic [WORD_W-1:0]         data_out;
  logic [BYTES_PER_WORD-1:0] keep_out;
  logic                      ready_out;

  modport master (
    output valid_in, data_in, last_in, ready_out,
    input  ready_in, valid_out, data_out, keep_out
  );

  modport slave (
    input  valid_in, data_in, last_in, ready_out,
    output ready_in, valid_out, data_out, keep_out
  );

endinterface

// File: rtl/conv_out_reg.sv
// Output holding register: loads a packed word, holds it until ready_out, 0-cycle pass.
// A load in the same edge as a drain replaces the word with no bubble.
module conv_out_reg
  import conv_pkg::*;
(
  input  logic                      clk_in,
  input  logic                      rst_n,
  input  logic                      i_load,
  input  logic [WORD_W-1:0]         i_data,
  input  logic [BYTES_PER_WORD-1:0] i_keep,
  conv_pack_8to64_if.slave          bus
);

  logic                      r_valid;
  logic [WORD_W-1:0]         r_data;
  logic [BYTES_PER_WORD-1:0] r_keep;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_keep  <= i_keep;
    end else if (r_valid && bus.ready_out) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.valid_out = r_valid;
  assign bus.data_out  = r_data;
  assign bus.keep_out  = r_keep;

endmodule

// File: rtl/conv_pack_8to64.sv
// Packs little-endian bytes into 64-bit words with keep mask; 1-cycle latency to valid_out.
// ready_in drops only while a completed word waits behind an undrained output register.
module conv_pack_8to64
  import conv_pkg::*;
(
  input  logic                      clk_in,
  input  logic                      rst_n,
  input  logic                      valid_in,
  input  logic [BYTE_W-1:0]         data_in,
  input  logic                      last_in,
  output logic                      ready_in,
  output logic                      valid_out,
  output logic [WORD_W-1:0]         data_out,
  output logic [BYTES_PER_WORD-1:0] keep_out,
  input  logic                      ready_out
);

  conv_pack_8to64_if u_bus ();

  state_e                    r_state, w_state_nxt;
  logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;
  logic [WORD_W-1:0]         r_acc_data, w_acc_data_nxt, w_merged_data, w_load_data;
  logic [BYTES_PER_WORD-1:0] r_acc_keep, w_acc_keep_nxt, w_merged_keep, w_load_keep;
  logic                      w_accept, w_complete, w_out_free, w_drain, w_load;

  assign u_bus.valid_in  = valid_in;
  assign u_bus.data_in   = data_in;
  assign u_bus.last_in   = last_in;
  assign u_bus.ready_out = ready_out;
  assign u_bus.ready_in  = (r_state != FULL);

  assign ready_in  = u_bus.ready_in;
  assign valid_out = u_bus.valid_out;
  assign data_out  = u_bus.data_out;
  assign keep_out  = u_bus.keep_out;

  assign w_accept      = valid_in && u_bus.ready_in;
  assign w_complete    = w_accept && (last_in || (r_cnt == CNT_W'(BYTES_PER_WORD - 1)));
  assign w_drain       = u_bus.valid_out && ready_out;
  assign w_out_free    = !u_bus.valid_out || ready_out;
  assign w_merged_data = r_acc_data | (WORD_W'(data_in) << {r_cnt, 3'b000});
  assign w_merged_keep = r_acc_keep | (BYTES_PER_WORD'(1) << r_cnt);

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_acc_data_nxt = r_acc_data;
    w_acc_keep_nxt = r_acc_keep;
    w_load         = 1'b0;
    w_load_data    = w_merged_data;
    w_load_keep    = w_merged_keep;
    case (r_state)
      EMPTY, FILL: begin
        if (w_complete) begin
          w_cnt_nxt = '0;
          if (w_out_free) begin
            w_load         = 1'b1;
            w_state_nxt    = EMPTY;
            w_acc_data_nxt = '0;
            w_acc_keep_nxt = '0;
          end else begin
            // Completed word parks in the accumulator until the output drains.
            w_state_nxt    = FULL;
            w_acc_data_nxt = w_merged_data;
            w_acc_keep_nxt = w_merged_keep;
          end
        end else if (w_accept) begin
          w_state_nxt    = FILL;
          w_cnt_nxt      = r_cnt + 1'b1;
          w_acc_data_nxt = w_merged_data;
          w_acc_keep_nxt = w_merged_keep;
        end
      end
      FULL: begin
        w_load_data = r_acc_data;
        w_load_keep = r_acc_keep;
        if (w_drain) begin
          w_load         = 1'b1;
          w_state_nxt    = EMPTY;
          w_acc_data_nxt = '0;
          w_acc_keep_nxt = '0;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_state    <= EMPTY;
      r_cnt      <= '0;
      r_acc_data <= '0;
      r_acc_keep <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_acc_data <= w_acc_data_nxt;
      r_acc_keep <= w_acc_keep_nxt;
    end
  end

  conv_out_reg u_out_reg (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_data (w_load_data),
    .i_keep (w_load_keep),
    .bus    (u_bus.slave)
  );

endmodule

// File: tb/tb_conv_pack_8to64.sv
// Scoreboard bench for conv_pack_8to64: a byte-list model predicts words, a monitor compares.
module tb_conv_pack_8to64;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
  } word_t;

  logic clk_in = 1'b0;
  logic rst_n;
  conv_pack_8to64_if bus ();

  always #5 clk_in = ~clk_in;

  conv_pack_8to64 dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .valid_in  (bus.valid_in),
    .data_in   (bus.data_in),
    .last_in   (bus.last_in),
    .ready_in  (bus.ready_in),
    .valid_out (bus.valid_out),
    .data_out  (bus.data_out),
    .keep_out  (bus.keep_out),
    .ready_out (bus.ready_out)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_words  = 0;
  int          stall_cnt = 0;
  logic [7:0]  cur_bytes[$];
  word_t       exp_q[$];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: a word is whatever bytes were taken since the last word, ending at 8 bytes or last.
  task automatic model_accept(input logic [7:0] b, input logic l);
    word_t w;
    cur_bytes.push_back(b);
    if (l || cur_bytes.size() == 8) begin
      w = '0;
      foreach (cur_bytes[i]) begin
        w.d[8*i +: 8] = cur_bytes[i];
        w.k[i]        = 1'b1;
      end
      exp_q.push_back(w);
      cur_bytes.delete();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    int waitc = 0;
    bus.valid_in = 1'b1;
    bus.data_in  = b;
    bus.last_in  = l;
    while (!bus.ready_in && waitc < 200) begin
      @(negedge clk_in);
      waitc++;
      stall_cnt++;
    end
    if (!bus.ready_in) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout actual=ready_in_low required=ready_in_high");
    end else begin
      model_accept(b, l);
    end
    @(negedge clk_in);
    bus.valid_in = 1'b0;
    bus.last_in  = 1'b0;
  endtask

  // Monitor: samples mid-low-phase, well clear of the rising edge.
  logic        prev_stall = 1'b0;
  logic [71:0] prev_word;
  always begin
    @(negedge clk_in);
    #3;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("hold_stable", {bus.valid_out, bus.data_out, bus.keep_out}, {1'b1, prev_word});
      if (bus.valid_out && bus.ready_out) begin
        n_words++;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {bus.data_out, bus.keep_out}, 72'h0);
        end else begin
          word_t w;
          w = exp_q.pop_front();
          chk("scoreboard_word", {bus.data_out, bus.keep_out}, {w.d, w.k});
        end
      end
      prev_stall = bus.valid_out && !bus.ready_out;
      prev_word  = {bus.data_out, bus.keep_out};
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  bp_bytes[16];
    logic [63:0] w1, w2;
    int          s0, wc0;
    bit          done;

    rst_n         = 1'b0;
    bus.valid_in  = 1'b0;
    bus.data_in   = '0;
    bus.last_in   = 1'b0;
    bus.ready_out = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
    chk("reset_valid_out", 72'(bus.valid_out), 72'h0);
    chk("reset_data_keep", {bus.data_out, bus.keep_out}, 72'h0);
    chk("reset_ready_in", 72'(bus.ready_in), 72'h1);

    // Full word
    bus.ready_out = 1'b1;
    for (int i = 1; i <= 8; i++) send_byte(8'(8'h11 * i), 1'b0);
    chk("full_word", {bus.valid_out, bus.data_out, bus.keep_out}, {1'b1, 64'h8877665544332211, 8'hFF});
    @(negedge clk_in);
    chk("full_word_one_cycle", 72'(bus.valid_out), 72'h0);

    // Partial word
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    send_byte(8'hA3, 1'b1);
    chk("partial_word", {bus.data_out, bus.keep_out}, {64'h0000_0000_00A3_A2A1, 8'h07});
    @(negedge clk_in);

    // Single-byte last
    send_byte(8'h5A, 1'b1);
    chk("single_last", {bus.data_out, bus.keep_out}, {64'h5A, 8'h01});
    @(negedge clk_in);

    // Backpressure
    bus.ready_out = 1'b0;
    foreach (bp_bytes[i]) bp_bytes[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) send_byte(bp_bytes[i], 1'b0);
    for (int i = 0; i < 8; i++) begin
      w1[8*i +: 8] = bp_bytes[i];
      w2[8*i +: 8] = bp_bytes[i+8];
    end
    chk("bp_ready_in_full", 72'(bus.ready_in), 72'h0);
    chk("bp_first_held", {bus.valid_out, bus.data_out}, {1'b1, w1});
    bus.ready_out = 1'b1;
    @(negedge clk_in);
    chk("bp_ready_in_after", 72'(bus.ready_in), 72'h1);
    chk("bp_second_no_bubble", {bus.valid_out, bus.data_out, bus.keep_out}, {1'b1, w2, 8'hFF});
    @(negedge clk_in);

    // Reset mid-word
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0);
    rst_n = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b1;
    cur_bytes.delete();
    exp_q.delete();
    chk("midreset_outputs", {bus.valid_out, bus.keep_out}, 72'h0);
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
    chk("after_reset_word", {bus.data_out, bus.keep_out}, {64'h0807060504030201, 8'hFF});
    @(negedge clk_in);

    // Streaming
    s0  = stall_cnt;
    wc0 = n_words;
    for (int i = 0; i < 64; i++) send_byte(8'($urandom), 1'b0);
    chk("stream_no_stall", 72'(stall_cnt - s0), 72'h0);
    @(negedge clk_in);
    chk("stream_word_count", 72'(n_words - wc0), 72'd8);

    // Random traffic with random backpressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          send_byte(8'($urandom), (i == 149) || ($urandom_range(0, 5) == 0));
          repeat ($urandom_range(0, 2)) @(negedge clk_in);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk_in);
          bus.ready_out = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.ready_out = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk_in);
    repeat (2) @(negedge clk_in);
    chk("drain_queue_empty", 72'(exp_q.size()), 72'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
